// File: rtl/support_mem_pkg.sv
// Shared definitions for the support-RAM loader and the supervisor-side drivers.
package support_mem_pkg;

    localparam int unsigned ADDR_W             = 16;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned ARM_CYCLES_DEFAULT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/support_mem_loader.sv
// Streams bytes into the support RAM while holding the supervisor CPU off the port.
//
// state   | meaning
// IDLE    | waiting for start; CPU owns the RAM port
// ARM     | loader owns the port, write mux settling, no writes
// LOAD    | accepting stream bytes, one RAM write per accepted byte
// RELEASE | one quiet cycle with the port still owned after the last write
// DONE    | done pulse, port handed back to the CPU
module support_mem_loader
    import support_mem_pkg::*;
#(
    parameter int unsigned ARM_CYCLES = ARM_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              sys_en,
    output logic [ADDR_W-1:0] sys_A,
    output logic [DATA_W-1:0] sys_data,
    output logic              sys_wr,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] checksum
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rem_q, rem_d;
    logic [7:0]        arm_cnt_q, arm_cnt_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              abort_seen_q, abort_seen_d;
    logic              aborted_q, aborted_d;
    logic              sys_en_q, sys_en_d;
    logic              sys_wr_q, sys_wr_d;
    logic [ADDR_W-1:0] sys_a_q, sys_a_d;
    logic [DATA_W-1:0] sys_data_q, sys_data_d;

    logic start_ok;
    logic active_abort;
    logic accept;

    assign start_ok     = (state_q == ST_IDLE) && start;
    assign active_abort = abort && ((state_q == ST_ARM) || (state_q == ST_LOAD));
    // abort gates ready combinationally so the byte on the bus that cycle is refused
    assign s_ready      = (state_q == ST_LOAD) && (rem_q != 16'd0) && !abort;
    assign accept       = s_ready && s_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            arm_cnt_q    <= '0;
            checksum_q   <= '0;
            abort_seen_q <= 1'b0;
            aborted_q    <= 1'b0;
            sys_en_q     <= 1'b0;
            sys_wr_q     <= 1'b0;
            sys_a_q      <= '0;
            sys_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            arm_cnt_q    <= arm_cnt_d;
            checksum_q   <= checksum_d;
            abort_seen_q <= abort_seen_d;
            aborted_q    <= aborted_d;
            sys_en_q     <= sys_en_d;
            sys_wr_q     <= sys_wr_d;
            sys_a_q      <= sys_a_d;
            sys_data_q   <= sys_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length == 16'd0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    state_d = ST_RELEASE;
                end else if (arm_cnt_q == 8'd0) begin
                    state_d = ST_LOAD;
                end
            end
            // rem_q reaches zero in the cycle the last write is on the bus
            ST_LOAD: begin
                if (abort || (rem_q == 16'd0)) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        rem_d        = rem_q;
        arm_cnt_d    = arm_cnt_q;
        checksum_d   = checksum_q;
        abort_seen_d = abort_seen_q;
        aborted_d    = aborted_q;
        sys_a_d      = sys_a_q;
        sys_data_d   = sys_data_q;
        sys_wr_d     = accept;
        sys_en_d     = (state_d == ST_ARM) || (state_d == ST_LOAD) || (state_d == ST_RELEASE);

        if (start_ok) begin
            addr_d       = base_addr;
            rem_d        = length;
            arm_cnt_d    = 8'(ARM_CYCLES - 1);
            checksum_d   = '0;
            abort_seen_d = 1'b0;
            aborted_d    = 1'b0;
        end

        if ((state_q == ST_ARM) && (arm_cnt_q != 8'd0)) begin
            arm_cnt_d = arm_cnt_q - 8'd1;
        end

        if (accept) begin
            sys_a_d    = addr_q;
            sys_data_d = s_data;
            addr_d     = addr_q + 16'd1;
            rem_d      = rem_q - 16'd1;
            checksum_d = checksum_q + s_data;
        end

        if (active_abort) begin
            abort_seen_d = 1'b1;
        end

        // aborted rises together with the done pulse
        if ((state_q == ST_RELEASE) && abort_seen_q) begin
            aborted_d = 1'b1;
        end
    end

    assign sys_en   = sys_en_q;
    assign sys_wr   = sys_wr_q;
    assign sys_A    = sys_a_q;
    assign sys_data = sys_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign aborted  = aborted_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_support_mem_loader.sv
// Scenario bench for support_mem_loader; RAM writes are checked against a queue of expected writes.
module tb_support_mem_loader;
    import support_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] length = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready, sys_en, sys_wr, busy, done, aborted;
    logic [15:0] sys_A;
    logic [7:0]  sys_data, checksum;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         en_cnt = 0;
    int         cyc = 0;
    int         first_wr = -1;
    int         last_wr = -1;
    logic [7:0] stim [16];

    always #5 clk = ~clk;

    support_mem_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .sys_en    (sys_en),
        .sys_A     (sys_A),
        .sys_data  (sys_data),
        .sys_wr    (sys_wr),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .checksum  (checksum)
    );

    // write monitor: every strobe must match the next expected write
    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (reset_n) begin
            if (sys_en === 1'b1) en_cnt++;
            if (done === 1'b1) done_cnt++;
            if (sys_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h", sys_A, sys_data);
                end else begin
                    w = exp_q.pop_front();
                    if ({sys_A, sys_data} !== w) begin
                        errors++;
                        $display("FAIL write addr/data got %h/%h want %h/%h", sys_A, sys_data, w.a, w.d);
                    end
                end
                checks++;
                if (sys_en !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_without_en sys_en=%b want 1", sys_en);
                end
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
        end
    end

    task automatic stream_bytes(input int n, input bit gaps, input bit poke);
        int idx = 0;
        int guard = 0;
        bit ph = 1'b1;
        while (idx < n && guard < 100) begin
            s_valid = gaps ? ph : 1'b1;
            ph      = ~ph;
            s_data  = stim[idx];
            start   = poke && (guard == 3);
            if (poke && guard == 3) base_addr = 16'hDEAD;
            #1;
            if (s_valid && s_ready) idx++;
            @(negedge clk);
            guard++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL stream_timeout accepted=%0d want=%0d", idx, n);
        end
    endtask

    task automatic finish_load(input string name, input int d0, input int w0, input int nwr,
                               input logic [7:0] sum, input logic ab);
        int guard = 0;
        while ((busy !== 1'b0 || done_cnt == d0) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt - d0);
        end
        checks++;
        if (wr_cnt - w0 != nwr) begin
            errors++;
            $display("FAIL %s write_count got=%0d want=%0d", name, wr_cnt - w0, nwr);
        end
        checks++;
        if (checksum !== sum) begin
            errors++;
            $display("FAIL %s checksum got=%h want=%h", name, checksum, sum);
        end
        checks++;
        if (aborted !== ab) begin
            errors++;
            $display("FAIL %s aborted got=%b want=%b", name, aborted, ab);
        end
        checks++;
        if (sys_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after got sys_en=%b busy=%b want 0/0", name, sys_en, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes got=%0d pending want=0", name, exp_q.size());
        end
    endtask

    task automatic run_load(input string name, input logic [15:0] base, input int n, input bit gaps,
                            input bit poke, input bit contig, input logic [7:0] sum);
        int d0 = done_cnt;
        int w0 = wr_cnt;
        first_wr = -1;
        for (int i = 0; i < n; i++) exp_q.push_back({base + 16'(i), stim[i]});
        base_addr = base;
        length    = 16'(n);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start_taken busy=%b want 1", name, busy);
        end
        stream_bytes(n, gaps, poke);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_after_last s_ready=%b want 0", name, s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        if (contig) begin
            checks++;
            if (last_wr - first_wr != n - 1) begin
                errors++;
                $display("FAIL %s contiguous span=%0d want=%0d", name, last_wr - first_wr, n - 1);
            end
        end
        finish_load(name, d0, w0, n, sum, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, sys_en, sys_wr, busy, done, aborted, sys_A, sys_data, checksum} !== '0) begin
            errors++;
            $display("FAIL reset_state got en=%b wr=%b busy=%b done=%b A=%h d=%h cs=%h want all 0",
                     sys_en, sys_wr, busy, done, sys_A, sys_data, checksum);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
        run_load("basic", 16'h1000, 4, 1'b0, 1'b0, 1'b1, 8'h0A);
    endtask

    task automatic test_wrap();
        stim[0] = 8'hAA;
        stim[1] = 8'hBB;
        stim[2] = 8'hCC;
        run_load("wrap", 16'hFFFE, 3, 1'b0, 1'b0, 1'b1, 8'h31);
    endtask

    task automatic test_empty();
        int d0  = done_cnt;
        int w0  = wr_cnt;
        int e0  = en_cnt;
        base_addr = 16'h0042;
        length    = 16'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL empty done_by_2 got=%0d want=1", done_cnt - d0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || en_cnt != e0 || wr_cnt != w0) begin
            errors++;
            $display("FAIL empty quiet done=%0d en=%0d wr=%0d want 1/0/0",
                     done_cnt - d0, en_cnt - e0, wr_cnt - w0);
        end
        checks++;
        if (checksum !== 8'h00) begin
            errors++;
            $display("FAIL empty checksum got=%h want=00", checksum);
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        int w0 = wr_cnt;
        for (int i = 0; i < 8; i++) stim[i] = 8'(16 * (i + 1));
        for (int i = 0; i < 3; i++) exp_q.push_back({16'h4000 + 16'(i), stim[i]});
        base_addr = 16'h4000;
        length    = 16'd8;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stream_bytes(3, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = stim[3];
        abort   = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort ready_in_abort s_ready=%b want 0", s_ready);
        end
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        finish_load("abort", d0, w0, 3, 8'h60, 1'b1);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 5; i++) stim[i] = 8'(17 * (i + 1));
        run_load("gaps", 16'h0100, 5, 1'b1, 1'b1, 1'b0, 8'hFF);
    endtask

    task automatic test_reset_mid();
        stim[0] = 8'h5A;
        stim[1] = 8'hA5;
        for (int i = 0; i < 2; i++) exp_q.push_back({16'h2000 + 16'(i), stim[i]});
        base_addr = 16'h2000;
        length    = 16'd8;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stream_bytes(2, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, sys_en, sys_wr, busy, done, aborted, sys_A, sys_data, checksum} !== '0) begin
            errors++;
            $display("FAIL reset_mid async got en=%b wr=%b busy=%b A=%h d=%h cs=%h want all 0",
                     sys_en, sys_wr, busy, sys_A, sys_data, checksum);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid partial_writes pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        reset_n = 1'b1;
        stim[0] = 8'h05;
        stim[1] = 8'h06;
        stim[2] = 8'h07;
        run_load("after_reset", 16'h3000, 3, 1'b0, 1'b0, 1'b1, 8'h12);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_empty();
        test_abort();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/support_mem_loader.md
SUPPORT_MEM_LOADER -- requirements
Module: support_mem_loader

Interface
REQ-001 Parameter ARM_CYCLES, default 1: idle cycles with sys_en high before first write, for mux settling.
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to begin a load, sampled in IDLE only.
REQ-005 abort  in  1  terminate an active load.
REQ-006 base_addr  in  16  first support-RAM address, captured on accepted start.
REQ-007 length  in  16  byte count, captured on accepted start; 0 = empty load.
REQ-008 s_valid  in  1  stream byte valid.
REQ-009 s_data  in  8  stream byte.
REQ-010 s_ready  out  1  loader accepts byte this cycle.
REQ-011 sys_en  out  1  loader owns support-RAM port; supervisor CPU locked out.
REQ-012 sys_A  out  16  write address.
REQ-013 sys_data  out  8  write data.
REQ-014 sys_wr  out  1  write strobe, one cycle per byte.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 done  out  1  one-cycle pulse at end of load (normal or aborted).
REQ-017 aborted  out  1  level, set with done when ended by abort; cleared on next accepted start.
REQ-018 checksum  out  8  sum mod 256 of bytes written in current/last load.

Function
REQ-019 States: IDLE, ARM, LOAD, RELEASE, DONE; encoding 3 bits.
REQ-020 IDLE: start=1 -> capture base_addr/length, clear checksum and aborted; length=0 -> DONE, else -> ARM.
REQ-021 ARM: sys_en=1, sys_wr=0, s_ready=0 for ARM_CYCLES cycles, then -> LOAD.
REQ-022 LOAD: s_ready=1 unless remaining count is 0; byte accepted when s_valid&s_ready.
REQ-023 Accepted byte at cycle N -> sys_A=current address, sys_data=byte, sys_wr=1 during cycle N+1; address +1 mod 65536, remaining -1, checksum += byte.
REQ-024 Address wraps 0xFFFF -> 0x0000 with no error indication.
REQ-025 Back-to-back acceptance sustains one write per cycle; s_valid gaps insert sys_wr=0 cycles.
REQ-026 After last byte accepted (remaining reaches 0), s_ready drops next cycle and FSM -> RELEASE once last sys_wr cycle completes.
REQ-027 RELEASE: sys_en=1, sys_wr=0 for exactly one cycle, then -> DONE.
REQ-028 DONE: done=1 one cycle, sys_en=0, -> IDLE.
REQ-029 abort in ARM or LOAD: s_ready=0 same cycle, byte presented that cycle not accepted; any pending write from previous cycle still completes; -> RELEASE; aborted=1.
REQ-030 abort in IDLE, RELEASE, DONE ignored; start outside IDLE ignored.
REQ-031 sys_wr never high while sys_en low; sys_en is registered, glitch-free.
REQ-032 checksum holds final value until next accepted start.

Reset
REQ-033 reset_n low -> state IDLE; s_ready, sys_en, sys_wr, busy, done, aborted = 0; sys_A, sys_data, checksum, counters = 0; effective immediately, including mid-load (partial writes remain in RAM).
REQ-034 First start honoured on first rising edge after reset_n deasserts.

Structure
REQ-035 State encodings and ARM_CYCLES default live in shared package support_mem_pkg, reused by supervisor-side drivers.
REQ-036 Single flat module; no sub-module required; instantiated beside support_memory_if, driving its sys_* port.

Verification
REQ-037 base=0x1000, length=4, bytes 01 02 03 04 continuous -> writes to 0x1000..0x1003 on consecutive cycles, checksum=0x0A, one done pulse, aborted=0.
REQ-038 base=0xFFFE, length=3, bytes AA BB CC -> writes at 0xFFFE, 0xFFFF, 0x0000; checksum=0x31.
REQ-039 length=0 start -> no sys_en, no sys_wr, done pulse two cycles after start, checksum=0.
REQ-040 length=8, abort asserted after 3rd acceptance with s_valid high -> exactly 3 writes, 4th byte not accepted, done=1 and aborted=1, sys_en low after RELEASE.
REQ-041 reset_n pulsed low mid-LOAD -> all outputs 0 asynchronously; new start after release performs a clean load.
REQ-042 s_valid toggling every other cycle, length=5 -> 5 writes, s_ready low after 5th, start pulses during busy ignored.
